jpeg_frame_ctrl: RTL and testbench

Frame-level sequencer for the JPEG encode path. Turns a user trigger, or free-running continuous mode, into properly spaced start pulses for the test pattern source and the JPEG encoder. It monitors the encoder's byte stream to find each frame's end, count its bytes and detect stalls, and sits between the board-level `start` input and the `start` inputs of the pattern source and encoder.

---
 rtl/jpeg_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_jpeg_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_frame_ctrl.sv
// Frame-level sequencer for the JPEG encode path: spaces encoder start pulses,
// counts each frame's bytes from the encoder strobe and watches for stalled frames.
module jpeg_frame_ctrl #(
   parameter int START_LEN      = 4,
   parameter int GAP_CYCLES     = 1024,
   parameter int TIMEOUT_CYCLES = 5_000_000,
   parameter int BYTE_W         = 20
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              trig,
   input  logic              cont_en,
   input  logic              send_data_vaild,
   input  logic              send_data_last,
   output logic              enc_start,
   output logic              busy,
   output logic              frame_done,
   output logic [BYTE_W-1:0] frame_bytes,
   output logic [15:0]       frame_cnt,
   output logic              timeout_err
);

   localparam int PH_MAX = (START_LEN > GAP_CYCLES) ? START_LEN : GAP_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int WD_W   = $clog2(TIMEOUT_CYCLES);

   localparam logic [PH_W-1:0] START_LAST = PH_W'(START_LEN - 1);
   localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_DONE,
      S_GAP
   } state_t;

   state_t            state;
   logic              trig_q;
   logic              trig_q_d;
   logic              pend;
   logic [PH_W-1:0]   phase_cnt;
   logic [WD_W-1:0]   wdog_cnt;
   logic [BYTE_W-1:0] byte_cnt;

   logic              trig_edge;
   logic              last_beat;
   logic [BYTE_W-1:0] byte_inc;

   // Rising edge is seen on the registered copy, so a start lands one clock after it is sampled.
   always_comb begin
      trig_edge = trig_q & ~trig_q_d;
      last_beat = send_data_vaild & send_data_last;
      byte_inc  = (&byte_cnt) ? byte_cnt : byte_cnt + BYTE_W'(1);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         trig_q      <= 1'b0;
         trig_q_d    <= 1'b0;
         pend        <= 1'b0;
         phase_cnt   <= '0;
         wdog_cnt    <= '0;
         byte_cnt    <= '0;
         enc_start   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_bytes <= '0;
         frame_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         trig_q     <= trig;
         trig_q_d   <= trig_q;
         frame_done <= 1'b0;

         // Only one request can be remembered while a frame is in flight.
         if (trig_edge && state != S_IDLE) begin
            pend <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (trig_edge || cont_en || pend) begin
                  state       <= S_START;
                  enc_start   <= 1'b1;
                  busy        <= 1'b1;
                  phase_cnt   <= '0;
                  wdog_cnt    <= '0;
                  byte_cnt    <= '0;
                  timeout_err <= 1'b0;
                  pend        <= 1'b0;
               end
            end

            S_START: begin
               if (last_beat) begin
                  state       <= S_DONE;
                  enc_start   <= 1'b0;
                  byte_cnt    <= byte_inc;
                  frame_done  <= 1'b1;
                  frame_bytes <= byte_inc;
                  frame_cnt   <= frame_cnt + 16'd1;
               end else begin
                  if (send_data_vaild) begin
                     byte_cnt <= byte_inc;
                  end
                  if (phase_cnt == START_LAST) begin
                     state     <= S_RUN;
                     enc_start <= 1'b0;
                     wdog_cnt  <= '0;
                  end else begin
                     phase_cnt <= phase_cnt + PH_W'(1);
                  end
               end
            end

            S_RUN: begin
               if (last_beat) begin
                  state       <= S_DONE;
                  byte_cnt    <= byte_inc;
                  frame_done  <= 1'b1;
                  frame_bytes <= byte_inc;
                  frame_cnt   <= frame_cnt + 16'd1;
               end else if (send_data_vaild) begin
                  byte_cnt <= byte_inc;
                  wdog_cnt <= '0;
               end else if (wdog_cnt == WD_LAST) begin
                  // A stalled frame is abandoned without touching the completed-frame outputs.
                  state       <= S_GAP;
                  phase_cnt   <= '0;
                  timeout_err <= 1'b1;
               end else begin
                  wdog_cnt <= wdog_cnt + WD_W'(1);
               end
            end

            S_DONE: begin
               state     <= S_GAP;
               phase_cnt <= '0;
            end

            S_GAP: begin
               if (phase_cnt == GAP_LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt + PH_W'(1);
               end
            end

            default: begin
               state     <= S_IDLE;
               enc_start <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Scoreboard bench for jpeg_frame_ctrl: a wide and a 4-bit byte counter instance
// share the same stimulus so saturation is checked on every frame.
module tb_jpeg_frame_ctrl;

   localparam int START_LEN = 4;
   localparam int GAP       = 8;
   localparam int TMO       = 50;

   logic sys_clk = 1'b0;
   logic rst_n;
   logic trig;
   logic cont_en;
   logic vaild;
   logic last;

   logic        a_enc_start, a_busy, a_frame_done, a_timeout_err;
   logic [19:0] a_frame_bytes;
   logic [15:0] a_frame_cnt;
   logic        b_enc_start, b_busy, b_frame_done, b_timeout_err;
   logic [3:0]  b_frame_bytes;
   logic [15:0] b_frame_cnt;

   typedef struct {
      int bytes;
      int cnt;
   } exp_t;

   exp_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   exp_cnt      = 0;
   int   cycle_cnt    = 0;

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cycle_cnt <= cycle_cnt + 1;

   jpeg_frame_ctrl #(
      .START_LEN(START_LEN), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .BYTE_W(20)
   ) dut_a (
      .sys_clk(sys_clk), .rst_n(rst_n), .trig(trig), .cont_en(cont_en),
      .send_data_vaild(vaild), .send_data_last(last),
      .enc_start(a_enc_start), .busy(a_busy), .frame_done(a_frame_done),
      .frame_bytes(a_frame_bytes), .frame_cnt(a_frame_cnt), .timeout_err(a_timeout_err)
   );

   jpeg_frame_ctrl #(
      .START_LEN(START_LEN), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .BYTE_W(4)
   ) dut_b (
      .sys_clk(sys_clk), .rst_n(rst_n), .trig(trig), .cont_en(cont_en),
      .send_data_vaild(vaild), .send_data_last(last),
      .enc_start(b_enc_start), .busy(b_busy), .frame_done(b_frame_done),
      .frame_bytes(b_frame_bytes), .frame_cnt(b_frame_cnt), .timeout_err(b_timeout_err)
   );

   task automatic check_output(input string name, input longint actual, input longint required);
      tests_run++;
      if (actual != required) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   task automatic report_fail(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: got timeout or unexpected event, expected normal response", name);
   endtask

   // Monitor: every frame_done pops one expected frame from the scoreboard.
   always @(negedge sys_clk) begin
      exp_t e;
      if (rst_n) begin
         if (a_frame_done) begin
            if (sb_q.size() == 0) begin
               report_fail("unexpected_frame_done");
            end else begin
               e = sb_q.pop_front();
               check_output("frame_bytes_a", a_frame_bytes, e.bytes);
               check_output("frame_cnt_a", a_frame_cnt, e.cnt);
               check_output("frame_done_b", b_frame_done, 1);
               check_output("frame_bytes_b_sat", b_frame_bytes, (e.bytes > 15) ? 15 : e.bytes);
            end
         end else if (b_frame_done) begin
            report_fail("frame_done_b_only");
         end
      end
   end

   task automatic pulse_trig();
      trig = 1'b1;
      @(negedge sys_clk);
      trig = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic wait_start(input bit chk_len, output bit ok, output int start_cycle);
      int len;
      ok = 1'b0;
      start_cycle = 0;
      for (int i = 0; i < 300; i++) begin
         if (a_enc_start) begin
            ok = 1'b1;
            break;
         end
         @(negedge sys_clk);
      end
      if (!ok) begin
         report_fail("enc_start_wait");
         return;
      end
      start_cycle = cycle_cnt;
      check_output("busy_at_start", a_busy, 1);
      if (chk_len) begin
         len = 1;
         for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (!a_enc_start) break;
            len++;
         end
         check_output("enc_start_len", len, START_LEN);
      end
   endtask

   task automatic apply_stimulus(input int n, input bit end_frame, input int prior);
      exp_t e;
      for (int i = 1; i <= n; i++) begin
         vaild = 1'b1;
         last  = end_frame && (i == n);
         if (last) begin
            exp_cnt++;
            e.bytes = prior + n;
            e.cnt   = exp_cnt;
            sb_q.push_back(e);
         end
         @(negedge sys_clk);
      end
      vaild = 1'b0;
      last  = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (a_busy && k < 200) begin
         @(negedge sys_clk);
         k++;
      end
      if (a_busy) report_fail("busy_fall_wait");
   endtask

   initial begin
      bit ok;
      int s1, s2, s3, k;

      rst_n   = 1'b0;
      trig    = 1'b0;
      cont_en = 1'b0;
      vaild   = 1'b0;
      last    = 1'b0;
      repeat (3) @(negedge sys_clk);
      check_output("reset_state_a",
         {a_enc_start, a_busy, a_frame_done, a_timeout_err, a_frame_bytes, a_frame_cnt}, 0);
      check_output("reset_state_b",
         {b_enc_start, b_busy, b_frame_done, b_timeout_err, b_frame_bytes, b_frame_cnt}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // Single triggered frame of 100 bytes.
      pulse_trig();
      wait_start(1'b1, ok, s1);
      apply_stimulus(100, 1'b1, 0);
      check_output("frame_done_single", a_frame_done, 1);
      k = 0;
      while (a_busy && k < 50) begin
         @(negedge sys_clk);
         k++;
      end
      check_output("busy_fall_after_done", k, GAP + 1);
      repeat (3) @(negedge sys_clk);

      // Continuous mode: 10, 20, 30 byte frames at minimum spacing.
      cont_en = 1'b1;
      wait_start(1'b1, ok, s1);
      apply_stimulus(10, 1'b1, 0);
      wait_start(1'b1, ok, s2);
      check_output("cont_spacing_1", s2 - s1, START_LEN + 10 + 1 + GAP + 1);
      apply_stimulus(20, 1'b1, 0);
      wait_start(1'b1, ok, s3);
      check_output("cont_spacing_2", s3 - s2, START_LEN + 20 + 1 + GAP + 1);
      apply_stimulus(30, 1'b1, 0);
      cont_en = 1'b0;
      wait_idle();
      repeat (20) @(negedge sys_clk);
      check_output("cont_stopped_busy", a_busy, 0);

      // Three trigger edges mid-frame yield exactly one extra frame.
      pulse_trig();
      wait_start(1'b1, ok, s1);
      apply_stimulus(5, 1'b0, 0);
      repeat (3) pulse_trig();
      apply_stimulus(3, 1'b1, 5);
      wait_start(1'b1, ok, s2);
      apply_stimulus(6, 1'b1, 0);
      wait_idle();
      repeat (30) @(negedge sys_clk);
      check_output("pend_single_extra", a_busy, 0);
      check_output("pend_frame_cnt", a_frame_cnt, exp_cnt);

      // Stall after 5 bytes: timeout without frame_done.
      pulse_trig();
      wait_start(1'b1, ok, s1);
      apply_stimulus(5, 1'b0, 0);
      k = 0;
      while (!a_timeout_err && k < 200) begin
         @(negedge sys_clk);
         k++;
      end
      check_output("timeout_err_set", a_timeout_err, 1);
      check_output("timeout_frame_cnt", a_frame_cnt, exp_cnt);
      wait_idle();
      check_output("timeout_sticky", a_timeout_err, 1);
      pulse_trig();
      wait_start(1'b0, ok, s1);
      check_output("timeout_clear_on_start", a_timeout_err, 0);
      wait_start(1'b1, ok, s1);
      apply_stimulus(7, 1'b1, 0);
      wait_idle();

      // Last beat while enc_start is still high.
      pulse_trig();
      wait_start(1'b0, ok, s1);
      apply_stimulus(2, 1'b1, 0);
      check_output("start_last_enc_drop", a_enc_start, 0);
      check_output("start_last_done", a_frame_done, 1);
      wait_idle();

      // Asynchronous reset in the middle of RUN.
      pulse_trig();
      wait_start(1'b1, ok, s1);
      apply_stimulus(3, 1'b0, 0);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_reset_a",
         {a_enc_start, a_busy, a_frame_done, a_timeout_err, a_frame_bytes, a_frame_cnt}, 0);
      check_output("async_reset_b",
         {b_enc_start, b_busy, b_frame_done, b_timeout_err, b_frame_bytes, b_frame_cnt}, 0);
      @(negedge sys_clk);
      rst_n   = 1'b1;
      exp_cnt = 0;
      @(negedge sys_clk);
      pulse_trig();
      wait_start(1'b1, ok, s1);
      apply_stimulus(4, 1'b1, 0);
      wait_idle();
      repeat (5) @(negedge sys_clk);

      check_output("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
